// File: rtl/booth_mul_scheduler.sv
// Round-robin front end that time-shares one Booth multiplier among NREQ requesters.
// One operation in flight: accept -> start pulse -> wait for done (watchdog) -> response.
module booth_mul_scheduler #(
  parameter int unsigned W       = 5,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 31
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*W-1:0]         req_a,
  input  logic [NREQ*W-1:0]         req_b,
  output logic [NREQ-1:0]           req_ready,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [2*W-1:0]            rsp_product,
  output logic                      rsp_err,
  output logic                      mul_start,
  output logic [W-1:0]              mul_a,
  output logic [W-1:0]              mul_q,
  output logic [3:0]                mul_cycle,
  input  logic                      mul_done,
  input  logic [2*W-1:0]            mul_product
);

  localparam int unsigned ID_W = $clog2(NREQ);
  localparam int unsigned PW   = 2 * W;
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          state;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] gidx;
  logic            grant_vld;
  logic [W-1:0]    a_sel;
  logic [W-1:0]    b_sel;
  logic            zero_op;
  logic [WD_W-1:0] wd_cnt;

  // First valid requester after the last one served, wrapping modulo NREQ.
  always_comb begin
    grant_vld = 1'b0;
    gidx      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!grant_vld && req_valid[ID_W'((32'(last_grant) + 32'd1 + k) % NREQ)]) begin
        grant_vld = 1'b1;
        gidx      = ID_W'((32'(last_grant) + 32'd1 + k) % NREQ);
      end
    end
  end

  assign a_sel     = req_a[32'(gidx) * W +: W];
  assign b_sel     = req_b[32'(gidx) * W +: W];
  assign zero_op   = (a_sel == '0) || (b_sel == '0);
  assign req_ready = (rst_n && (state == S_IDLE) && grant_vld) ? (NREQ'(1) << gidx) : '0;
  assign mul_cycle = 4'(W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      last_grant  <= ID_W'(NREQ - 1);
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_product <= '0;
      rsp_err     <= 1'b0;
      mul_start   <= 1'b0;
      mul_a       <= '0;
      mul_q       <= '0;
      wd_cnt      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_vld) begin
            last_grant <= gidx;
            rsp_id     <= gidx;
            if (zero_op) begin
              // A zero operand makes the product trivially zero; skip the multiplier.
              rsp_product <= '0;
              rsp_err     <= 1'b0;
              rsp_valid   <= 1'b1;
              state       <= S_RESP;
            end else begin
              mul_a     <= a_sel;
              mul_q     <= b_sel;
              mul_start <= 1'b1;
              state     <= S_START;
            end
          end
        end
        S_START: begin
          mul_start <= 1'b0;
          wd_cnt    <= '0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          // wd_cnt == 0 marks the first WAIT cycle, where a stale done is ignored.
          if ((wd_cnt != '0) && mul_done) begin
            rsp_product <= mul_product;
            rsp_err     <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= S_RESP;
          end else if (wd_cnt == WD_W'(TIMEOUT)) begin
            rsp_product <= PW'(0);
            rsp_err     <= 1'b1;
            rsp_valid   <= 1'b1;
            state       <= S_RESP;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
